filter_out_stage: RTL and testbench

FILTER_OUT_STAGE -- requirements
Module: filter_out_stage

---
 rtl/filter_out_stage.sv | 102 ++++++++++
 tb/tb_filter_out_stage.sv | 230 +++++++++++++++++++++++
 2 files changed

// File: rtl/filter_out_stage.sv
// filter_out_stage: decimates a Q16.16 sample stream, converts kept samples
// to saturated Q8.8 and buffers them in a small FIFO with valid/ready output.
// Optional build macro FILT_OUT_ROUND_EN: round half up before conversion
// (default build truncates and has no adder).
module filter_out_stage #(
    parameter int DEPTH = 4,
    parameter int CNT_W = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [31:0]      in,
    input  logic             in_valid,
    input  logic [CNT_W-1:0] decim,
    output logic [15:0]      out_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic             sat,
    output logic             ovf
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic signed [32:0] SAT_HI = 33'sd8388607;
    localparam logic signed [32:0] SAT_LO = -33'sd8388608;

    logic [CNT_W-1:0]  cnt;
    logic [AW-1:0]     wptr;
    logic [AW-1:0]     rptr;
    logic [AW:0]       count;
    logic [15:0]       mem [DEPTH];

    logic              keep;
    logic              push;
    logic              pop;
    logic              full;
    logic              wr;
    logic              clip;
    logic [15:0]       conv;
    logic signed [32:0] rnd;

`ifdef FILT_OUT_ROUND_EN
    // one extra bit so the rounding add cannot wrap near +full-scale
    assign rnd = $signed({in[31], in}) + 33'sd128;
`else
    assign rnd = $signed({in[31], in});
`endif

    assign keep      = (cnt >= decim);
    assign push      = in_valid && keep;
    assign out_valid = (count != '0);
    assign full      = (count == (AW+1)'(DEPTH));
    assign pop       = out_valid && out_ready;
    assign wr        = push && (!full || pop);
    assign out_data  = out_valid ? mem[rptr] : '0;

    // Q16.16 -> Q8.8 extraction with clipping to the Q8.8 range
    always_comb begin
        clip = 1'b0;
        conv = rnd[23:8];
        if (rnd > SAT_HI) begin
            conv = 16'h7FFF;
            clip = 1'b1;
        end else if (rnd < SAT_LO) begin
            conv = 16'h8000;
            clip = 1'b1;
        end
    end

    // decimation counter, FIFO pointers/occupancy and sticky status flags
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt   <= '0;
            wptr  <= '0;
            rptr  <= '0;
            count <= '0;
            sat   <= 1'b0;
            ovf   <= 1'b0;
        end else begin
            if (in_valid)
                cnt <= keep ? '0 : cnt + 1'b1;
            if (push && clip)
                sat <= 1'b1;
            if (push && full && !pop)
                ovf <= 1'b1;
            if (wr)
                wptr <= wptr + 1'b1;
            if (pop)
                rptr <= rptr + 1'b1;
            case ({wr, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    // FIFO storage; stale entries are hidden by the occupancy gate on out_data
    always_ff @(posedge clk) begin
        if (wr)
            mem[wptr] <= conv;
    end

endmodule

// File: tb/tb_filter_out_stage.sv
// tb_filter_out_stage: scoreboard bench for filter_out_stage (DEPTH=4, CNT_W=4).
module tb_filter_out_stage;

    localparam int DEPTH = 4;

    logic        clk;
    logic        rst;
    logic [31:0] din;
    logic        din_valid;
    logic [3:0]  decim;
    logic [15:0] out_data;
    logic        out_valid;
    logic        out_ready;
    logic        sat;
    logic        ovf;

    int n_tests = 0;
    int n_fail  = 0;
    int n_pops  = 0;

    logic [15:0] exp_q [$];
    int          m_cnt = 0;
    logic        m_sat = 1'b0;
    logic        m_ovf = 1'b0;

    filter_out_stage #(.DEPTH(DEPTH), .CNT_W(4)) dut (
        .clk       (clk),
        .rst       (rst),
        .in        (din),
        .in_valid  (din_valid),
        .decim     (decim),
        .out_data  (out_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .sat       (sat),
        .ovf       (ovf)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
        end
    endtask

    // reference conversion done in wide integer arithmetic
    function automatic logic [15:0] ref_conv(input logic [31:0] x, output bit clipped);
        longint v;
        v = longint'($signed(x));
`ifdef FILT_OUT_ROUND_EN
        v = v + 128;
`endif
        clipped = 1'b1;
        if (v > 64'sd8388607)       return 16'h7FFF;
        else if (v < -64'sd8388608) return 16'h8000;
        clipped = 1'b0;
        return v[23:8];
    endfunction

    // inputs change at posedge+1, so the negedge sees what the next edge will do
    always @(negedge clk) begin
        logic [15:0] e;
        bit          c;
        bit          popped;
        if (!rst) begin
            exp_q.delete();
            m_cnt = 0;
            m_sat = 1'b0;
            m_ovf = 1'b0;
        end else begin
            check("valid", out_valid, exp_q.size() != 0);
            check("sat", sat, m_sat);
            check("ovf", ovf, m_ovf);
            if (exp_q.size() == 0)
                check("idle_data", out_data, 32'h0);
            popped = out_ready && exp_q.size() != 0;
            if (popped) begin
                e = exp_q.pop_front();
                check("data", out_data, e);
                n_pops++;
            end
            if (din_valid) begin
                if (m_cnt >= int'(decim)) begin
                    m_cnt = 0;
                    e = ref_conv(din, c);
                    if (c) m_sat = 1'b1;
                    if (exp_q.size() < DEPTH) exp_q.push_back(e);
                    else m_ovf = 1'b1;
                end else begin
                    m_cnt++;
                end
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [31:0] d);
        din_valid = 1'b1;
        din       = d;
        step();
        din_valid = 1'b0;
    endtask

    task automatic do_reset();
        rst = 1'b0;
        step();
        rst = 1'b1;
        step();
    endtask

    initial begin
        int p0;
        logic [15:0] round_exp;
        rst = 1'b0; din = '0; din_valid = 1'b0; decim = '0; out_ready = 1'b0;
        step(); step();
        check("rst_valid", out_valid, 0);
        check("rst_data", out_data, 0);
        check("rst_sat", sat, 0);
        check("rst_ovf", ovf, 0);
        rst = 1'b1;
        step();

        // passthrough, latency 1
        out_ready = 1'b1;
        send(32'h0001_8000);
        check("pass_valid", out_valid, 1);
        check("pass_data", out_data, 16'h0180);
        check("pass_sat", sat, 0);
        step();

        // saturation both ways, sticky flag
        send(32'h0100_0000);
        check("sat_hi", out_data, 16'h7FFF);
        send(32'hFE00_0000);
        check("sat_lo", out_data, 16'h8000);
        check("sat_set", sat, 1);
        step(); step(); step();
        check("sat_sticky", sat, 1);

        // decimation by 3
        decim = 4'd2;
        p0 = n_pops;
        for (int n = 1; n <= 9; n++) begin
            din_valid = 1'b1;
            din = 32'(n) << 8;
            step();
        end
        din_valid = 1'b0;
        step(); step();
        check("decim_count", n_pops - p0, 3);

        // fill past full, then drain
        do_reset();
        decim = '0;
        out_ready = 1'b0;
        for (int n = 1; n <= 6; n++) send(32'(n) << 8);
        check("ovf_set", ovf, 1);
        check("full_head", out_data, 16'h0001);
        p0 = n_pops;
        out_ready = 1'b1;
        for (int i = 0; i < 6; i++) step();
        check("drain_pops", n_pops - p0, 4);
        check("drain_valid", out_valid, 0);
        check("drain_data", out_data, 0);

        // full with simultaneous push and pop
        do_reset();
        out_ready = 1'b0;
        for (int n = 1; n <= 4; n++) send(32'(n) << 8);
        out_ready = 1'b1;
        send(32'h0000_0500);
        out_ready = 1'b0;
        check("full_pp_count", 32'(dut.count), 4);
        check("full_pp_ovf", ovf, 0);
        out_ready = 1'b1;
        for (int i = 0; i < 5; i++) step();

        // reset mid-stream, restart count after release, rounding behaviour
        out_ready = 1'b0;
        for (int n = 1; n <= 3; n++) send(32'(n) << 8);
        check("pre_rst_valid", out_valid, 1);
        rst = 1'b0;
        #1;
        check("rst_async_valid", out_valid, 0);
        check("rst_async_data", out_data, 0);
        step();
        rst = 1'b1;
        step();
        send(32'h0000_00FF);
`ifdef FILT_OUT_ROUND_EN
        round_exp = 16'h0001;
`else
        round_exp = 16'h0000;
`endif
        check("round_valid", out_valid, 1);
        check("round_data", out_data, round_exp);
        out_ready = 1'b1;
        step(); step();

        // randomised traffic incl. decim changes mid-count and near-threshold data
        for (int i = 0; i < 400; i++) begin
            if ((i % 23) == 0) decim = 4'($urandom_range(0, 4));
            out_ready = ($urandom_range(0, 3) != 0);
            din_valid = ($urandom_range(0, 3) != 0);
            case ($urandom_range(0, 3))
                0: din = $urandom;
                1: din = 32'($signed(24'($urandom)));
                2: din = 32'h007F_FF00 + 32'($urandom_range(0, 511));
                default: din = 32'hFF7F_FF00 + 32'($urandom_range(0, 511));
            endcase
            step();
        end
        din_valid = 1'b0;
        out_ready = 1'b1;
        for (int i = 0; i < DEPTH + 2; i++) step();
        check("final_empty", out_valid, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
